// File: rtl/pong_engine.sv
// Pong game/render stage fed by a 640x480 VGA timing generator: paddle, ball and score
// state advance once per frame; pixel colour is registered one cycle behind h/v.
module pong_engine #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned PADDLE_W     = 8,
    parameter int unsigned PADDLE_H     = 64,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned P1_X         = 16,
    parameter int unsigned P2_X         = 616,
    parameter int unsigned PADDLE_STEP  = 4,
    parameter int unsigned BALL_SPEED   = 2,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    output logic [2:0] rgb,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic [1:0] o_dbg_state,
    output logic [9:0] o_dbg_bx,
    output logic [9:0] o_dbg_by,
    output logic [9:0] o_dbg_p1_y,
    output logic [9:0] o_dbg_p2_y,
    output logic       o_dbg_dx,
    output logic       o_dbg_dy
);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);

    // 11-bit copies so sums like y+PADDLE_H+STEP never wrap before compare.
    localparam logic [10:0] L_HA    = 11'(H_ACTIVE);
    localparam logic [10:0] L_VA    = 11'(V_ACTIVE);
    localparam logic [10:0] L_PW    = 11'(PADDLE_W);
    localparam logic [10:0] L_PH    = 11'(PADDLE_H);
    localparam logic [10:0] L_BS    = 11'(BALL_SIZE);
    localparam logic [10:0] L_P1X   = 11'(P1_X);
    localparam logic [10:0] L_P2X   = 11'(P2_X);
    localparam logic [10:0] L_STEP  = 11'(PADDLE_STEP);
    localparam logic [10:0] L_SP    = 11'(BALL_SPEED);
    localparam logic [10:0] L_LN_LO = 11'(H_ACTIVE / 2 - 2);
    localparam logic [10:0] L_LN_HI = 11'(H_ACTIVE / 2 + 1);

    localparam logic [9:0] P_STEP    = 10'(PADDLE_STEP);
    localparam logic [9:0] P_SP      = 10'(BALL_SPEED);
    localparam logic [9:0] P_PY_MAX  = 10'(V_ACTIVE - PADDLE_H);
    localparam logic [9:0] P_BY_MAX  = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0] P_L_STOP  = 10'(P1_X + PADDLE_W);
    localparam logic [9:0] P_R_STOP  = 10'(P2_X - BALL_SIZE);
    localparam logic [9:0] BX_C      = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [9:0] BY_C      = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [9:0] PY_C      = 10'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic [9:0] V_TICK    = 10'(V_ACTIVE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [3:0] SCORE_LAST = 4'(WIN_SCORE - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_serve_cnt;
    logic [9:0]       r_bx;
    logic [9:0]       r_by;
    logic             r_dx;
    logic             r_dy;
    logic [9:0]       r_p1_y;
    logic [9:0]       r_p2_y;
    logic [3:0]       r_score_l;
    logic [3:0]       r_score_r;
    logic             r_game_over;
    logic [2:0]       r_rgb;

    logic        w_frame_tick;
    logic [10:0] w_h;
    logic [10:0] w_v;
    logic [10:0] w_bx;
    logic [10:0] w_by;
    logic [10:0] w_p1;
    logic [10:0] w_p2;
    logic [9:0]  w_p1_y_nxt;
    logic [9:0]  w_p2_y_nxt;
    logic [9:0]  w_bx_nxt;
    logic [9:0]  w_by_nxt;
    logic        w_dx_nxt;
    logic        w_dy_nxt;
    logic        w_miss_l;
    logic        w_miss_r;
    logic        w_p1_ov;
    logic        w_p2_ov;
    logic        w_in_ball;
    logic        w_in_pad;
    logic        w_in_line;
    logic [2:0]  w_rgb_nxt;

    assign w_frame_tick = (h_count == 10'd0) && (v_count == V_TICK);
    assign w_h  = {1'b0, h_count};
    assign w_v  = {1'b0, v_count};
    assign w_bx = {1'b0, r_bx};
    assign w_by = {1'b0, r_by};
    assign w_p1 = {1'b0, r_p1_y};
    assign w_p2 = {1'b0, r_p2_y};

    function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up,
                                               input logic dn);
        logic [9:0] nxt;
        nxt = y;
        if (up && !dn)
            nxt = ({1'b0, y} >= L_STEP) ? y - P_STEP : 10'd0;
        else if (dn && !up)
            nxt = ({1'b0, y} + L_PH + L_STEP <= L_VA) ? y + P_STEP : P_PY_MAX;
        return nxt;
    endfunction

    assign w_p1_y_nxt = paddle_next(r_p1_y, p1_up, p1_down);
    assign w_p2_y_nxt = paddle_next(r_p2_y, p2_up, p2_down);

    assign w_p1_ov = (w_by + L_BS > w_p1) && (w_by < w_p1 + L_PH);
    assign w_p2_ov = (w_by + L_BS > w_p2) && (w_by < w_p2 + L_PH);

    // Per-axis ball step for one PLAY frame; misses are flagged, not applied here.
    always_comb begin
        w_bx_nxt = r_bx;
        w_by_nxt = r_by;
        w_dx_nxt = r_dx;
        w_dy_nxt = r_dy;
        w_miss_l = 1'b0;
        w_miss_r = 1'b0;

        if (r_dy && (w_by + L_BS + L_SP >= L_VA)) begin
            w_by_nxt = P_BY_MAX;
            w_dy_nxt = 1'b0;
        end else if (!r_dy && (w_by <= L_SP)) begin
            w_by_nxt = 10'd0;
            w_dy_nxt = 1'b1;
        end else begin
            w_by_nxt = r_dy ? r_by + P_SP : r_by - P_SP;
        end

        if (!r_dx) begin
            if ((w_bx <= L_P1X + L_PW + L_SP) && (w_bx >= L_P1X + L_PW) && w_p1_ov) begin
                w_bx_nxt = P_L_STOP;
                w_dx_nxt = 1'b1;
            end else if (w_bx <= L_SP) begin
                w_miss_l = 1'b1;
            end else begin
                w_bx_nxt = r_bx - P_SP;
            end
        end else begin
            if ((w_bx + L_BS + L_SP >= L_P2X) && (w_bx + L_BS <= L_P2X) && w_p2_ov) begin
                w_bx_nxt = P_R_STOP;
                w_dx_nxt = 1'b0;
            end else if (w_bx + L_BS + L_SP >= L_HA) begin
                w_miss_r = 1'b1;
            end else begin
                w_bx_nxt = r_bx + P_SP;
            end
        end
    end

    assign w_in_ball = (w_h >= w_bx) && (w_h < w_bx + L_BS) &&
                       (w_v >= w_by) && (w_v < w_by + L_BS);
    assign w_in_pad  = ((w_h >= L_P1X) && (w_h < L_P1X + L_PW) &&
                        (w_v >= w_p1) && (w_v < w_p1 + L_PH)) ||
                       ((w_h >= L_P2X) && (w_h < L_P2X + L_PW) &&
                        (w_v >= w_p2) && (w_v < w_p2 + L_PH));
    assign w_in_line = (w_h >= L_LN_LO) && (w_h <= L_LN_HI) && !v_count[4];

    always_comb begin
        w_rgb_nxt = 3'b000;
        if ((w_h >= L_HA) || (w_v >= L_VA))
            w_rgb_nxt = 3'b000;
        else if (w_in_ball && (r_state != ST_OVER))
            w_rgb_nxt = 3'b110;
        else if (w_in_pad)
            w_rgb_nxt = 3'b111;
        else if (w_in_line)
            w_rgb_nxt = 3'b001;
        else if (r_state == ST_OVER)
            w_rgb_nxt = 3'b100;
    end

    // Game FSM: every state change waits for frame_tick; OVER is left only via Reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state     <= ST_SERVE;
            r_serve_cnt <= '0;
            r_bx        <= BX_C;
            r_by        <= BY_C;
            r_dx        <= 1'b1;
            r_dy        <= 1'b1;
            r_p1_y      <= PY_C;
            r_p2_y      <= PY_C;
            r_score_l   <= 4'd0;
            r_score_r   <= 4'd0;
            r_game_over <= 1'b0;
            r_rgb       <= 3'b000;
        end else begin
            r_rgb <= w_rgb_nxt;
            if (w_frame_tick) begin
                case (r_state)
                    ST_SERVE: begin
                        r_p1_y <= w_p1_y_nxt;
                        r_p2_y <= w_p2_y_nxt;
                        if (r_serve_cnt == CNT_LAST) begin
                            r_state     <= ST_PLAY;
                            r_serve_cnt <= '0;
                        end else begin
                            r_serve_cnt <= r_serve_cnt + CNT_W'(1);
                        end
                    end
                    ST_PLAY: begin
                        r_p1_y <= w_p1_y_nxt;
                        r_p2_y <= w_p2_y_nxt;
                        if (w_miss_l) begin
                            r_score_r   <= r_score_r + 4'd1;
                            r_bx        <= BX_C;
                            r_by        <= BY_C;
                            r_dx        <= 1'b0;
                            r_serve_cnt <= '0;
                            r_state     <= (r_score_r == SCORE_LAST) ? ST_OVER : ST_SERVE;
                            r_game_over <= (r_score_r == SCORE_LAST);
                        end else if (w_miss_r) begin
                            r_score_l   <= r_score_l + 4'd1;
                            r_bx        <= BX_C;
                            r_by        <= BY_C;
                            r_dx        <= 1'b1;
                            r_serve_cnt <= '0;
                            r_state     <= (r_score_l == SCORE_LAST) ? ST_OVER : ST_SERVE;
                            r_game_over <= (r_score_l == SCORE_LAST);
                        end else begin
                            r_bx <= w_bx_nxt;
                            r_by <= w_by_nxt;
                            r_dx <= w_dx_nxt;
                            r_dy <= w_dy_nxt;
                        end
                    end
                    default: begin
                        r_game_over <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign rgb         = r_rgb;
    assign score_l     = r_score_l;
    assign score_r     = r_score_r;
    assign game_over   = r_game_over;
    assign o_dbg_state = r_state;
    assign o_dbg_bx    = r_bx;
    assign o_dbg_by    = r_by;
    assign o_dbg_p1_y  = r_p1_y;
    assign o_dbg_p2_y  = r_p2_y;
    assign o_dbg_dx    = r_dx;
    assign o_dbg_dy    = r_dy;

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: frame ticks are driven as h=0,v=480 for one cycle,
// and game state is observed through the debug outputs and rendered pixels.
module tb_pong_engine;
    localparam int ST_SERVE = 0;
    localparam int ST_PLAY  = 1;
    localparam int ST_OVER  = 2;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] h_count = 10'd1;
    logic [9:0] v_count = 10'd480;
    logic       p1_up = 1'b0;
    logic       p1_down = 1'b0;
    logic       p2_up = 1'b0;
    logic       p2_down = 1'b0;
    logic [2:0] rgb;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;
    logic [1:0] dbg_state;
    logic [9:0] dbg_bx;
    logic [9:0] dbg_by;
    logic [9:0] dbg_p1_y;
    logic [9:0] dbg_p2_y;
    logic       dbg_dx;
    logic       dbg_dy;

    int errors = 0;
    int checks = 0;
    int t_now  = 0;

    always #5 clk = ~clk;

    pong_engine dut (
        .clk        (clk),
        .Reset      (Reset),
        .h_count    (h_count),
        .v_count    (v_count),
        .p1_up      (p1_up),
        .p1_down    (p1_down),
        .p2_up      (p2_up),
        .p2_down    (p2_down),
        .rgb        (rgb),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over),
        .o_dbg_state(dbg_state),
        .o_dbg_bx   (dbg_bx),
        .o_dbg_by   (dbg_by),
        .o_dbg_p1_y (dbg_p1_y),
        .o_dbg_p2_y (dbg_p2_y),
        .o_dbg_dx   (dbg_dx),
        .o_dbg_dy   (dbg_dy)
    );

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic [2:0] exp;
        string      name;
    } pix_t;

    typedef struct {
        int tick;
        int st;
        int bx;
        int by;
        int dx;
        int dy;
        int p1;
        int p2;
        int sl;
        int sr;
    } frm_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic frame_tick();
        @(negedge clk);
        h_count = 10'd0;
        v_count = 10'd480;
        @(negedge clk);
        h_count = 10'd1;
    endtask

    task automatic run_to(input int target);
        while (t_now < target) begin
            frame_tick();
            t_now++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset   = 1'b1;
        h_count = 10'd1;
        v_count = 10'd480;
        @(negedge clk);
        Reset = 1'b0;
        t_now = 0;
    endtask

    task automatic check_state(input string tag, input int st, input int bx, input int by,
                               input int dx, input int dy, input int p1, input int p2,
                               input int sl, input int sr);
        check($sformatf("%s.state", tag), 32'(dbg_state), st);
        check($sformatf("%s.bx", tag), 32'(dbg_bx), bx);
        check($sformatf("%s.by", tag), 32'(dbg_by), by);
        check($sformatf("%s.dx", tag), 32'(dbg_dx), dx);
        check($sformatf("%s.dy", tag), 32'(dbg_dy), dy);
        check($sformatf("%s.p1_y", tag), 32'(dbg_p1_y), p1);
        check($sformatf("%s.p2_y", tag), 32'(dbg_p2_y), p2);
        check($sformatf("%s.score_l", tag), 32'(score_l), sl);
        check($sformatf("%s.score_r", tag), 32'(score_r), sr);
    endtask

    task automatic check_pix(input string tag, input logic [9:0] h, input logic [9:0] v,
                             input logic [2:0] exp);
        @(negedge clk);
        h_count = h;
        v_count = v;
        @(negedge clk);
        check(tag, 32'(rgb), 32'(exp));
        h_count = 10'd1;
        v_count = 10'd480;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pix_t pix_tab[14];
        frm_t a_tab[14];
        logic tgt;
        bit   reached;
        int   n;

        pix_tab[0]  = '{10'd316, 10'd236, 3'b110, "ball"};
        pix_tab[1]  = '{10'd20,  10'd210, 3'b111, "p1"};
        pix_tab[2]  = '{10'd319, 10'd5,   3'b001, "line"};
        pix_tab[3]  = '{10'd319, 10'd20,  3'b000, "line_gap"};
        pix_tab[4]  = '{10'd700, 10'd100, 3'b000, "h_blank"};
        pix_tab[5]  = '{10'd323, 10'd243, 3'b110, "ball_corner"};
        pix_tab[6]  = '{10'd324, 10'd243, 3'b000, "ball_right"};
        pix_tab[7]  = '{10'd320, 10'd236, 3'b110, "ball_over_line"};
        pix_tab[8]  = '{10'd620, 10'd271, 3'b111, "p2_last_row"};
        pix_tab[9]  = '{10'd620, 10'd272, 3'b000, "p2_below"};
        pix_tab[10] = '{10'd5,   10'd490, 3'b000, "v_blank"};
        pix_tab[11] = '{10'd16,  10'd208, 3'b111, "p1_corner"};
        pix_tab[12] = '{10'd15,  10'd208, 3'b000, "p1_left"};
        pix_tab[13] = '{10'd24,  10'd208, 3'b000, "p1_right"};

        // p1 idle at 208, p2 held down from reset.
        a_tab[0]  = '{51,  ST_SERVE, 316, 236, 1, 1, 208, 412, 0, 0};
        a_tab[1]  = '{52,  ST_SERVE, 316, 236, 1, 1, 208, 416, 0, 0};
        a_tab[2]  = '{59,  ST_SERVE, 316, 236, 1, 1, 208, 416, 0, 0};
        a_tab[3]  = '{60,  ST_PLAY,  316, 236, 1, 1, 208, 416, 0, 0};
        a_tab[4]  = '{61,  ST_PLAY,  318, 238, 1, 1, 208, 416, 0, 0};
        a_tab[5]  = '{62,  ST_PLAY,  320, 240, 1, 1, 208, 416, 0, 0};
        a_tab[6]  = '{177, ST_PLAY,  550, 470, 1, 1, 208, 416, 0, 0};
        a_tab[7]  = '{178, ST_PLAY,  552, 472, 1, 0, 208, 416, 0, 0};
        a_tab[8]  = '{205, ST_PLAY,  606, 418, 1, 0, 208, 416, 0, 0};
        a_tab[9]  = '{206, ST_PLAY,  608, 416, 0, 0, 208, 416, 0, 0};
        a_tab[10] = '{413, ST_PLAY,  194, 2,   0, 0, 208, 416, 0, 0};
        a_tab[11] = '{414, ST_PLAY,  192, 0,   0, 1, 208, 416, 0, 0};
        a_tab[12] = '{509, ST_PLAY,  2,   190, 0, 1, 208, 416, 0, 0};
        a_tab[13] = '{510, ST_SERVE, 316, 236, 0, 1, 208, 416, 0, 1};

        // Reset state and static rendering.
        do_reset();
        check("rst.rgb", 32'(rgb), 32'd0);
        check("rst.game_over", 32'(game_over), 32'd0);
        check_state("rst", ST_SERVE, 316, 236, 1, 1, 208, 208, 0, 0);
        for (int i = 0; i < 14; i++)
            check_pix(pix_tab[i].name, pix_tab[i].h, pix_tab[i].v, pix_tab[i].exp);

        // Serve delay, bottom wall, right paddle hit, top wall, left miss.
        do_reset();
        p2_down = 1'b1;
        for (int i = 0; i < 14; i++) begin
            run_to(a_tab[i].tick);
            check_state($sformatf("a%0d", a_tab[i].tick), a_tab[i].st, a_tab[i].bx,
                        a_tab[i].by, a_tab[i].dx, a_tab[i].dy, a_tab[i].p1, a_tab[i].p2,
                        a_tab[i].sl, a_tab[i].sr);
        end
        p2_down = 1'b0;

        // Paddle clamps and hold, then a right-side miss with p2 parked at the top.
        do_reset();
        p1_up = 1'b1;
        p2_up = 1'b1;
        run_to(51);
        check_state("b51", ST_SERVE, 316, 236, 1, 1, 4, 4, 0, 0);
        run_to(52);
        check_state("b52", ST_SERVE, 316, 236, 1, 1, 0, 0, 0, 0);
        run_to(60);
        check_state("b60", ST_PLAY, 316, 236, 1, 1, 0, 0, 0, 0);
        p1_up   = 1'b0;
        p1_down = 1'b1;
        run_to(163);
        check_state("b163", ST_PLAY, 522, 442, 1, 1, 412, 0, 0, 0);
        run_to(164);
        check_state("b164", ST_PLAY, 524, 444, 1, 1, 416, 0, 0, 0);
        p1_up = 1'b1;
        run_to(180);
        check_state("b180", ST_PLAY, 556, 468, 1, 0, 416, 0, 0, 0);
        p1_up   = 1'b0;
        p1_down = 1'b0;
        run_to(217);
        check_state("b217", ST_PLAY, 630, 394, 1, 0, 416, 0, 0, 0);
        run_to(218);
        check_state("b218", ST_SERVE, 316, 236, 1, 0, 416, 0, 1, 0);

        // Keep p2 on the side the ball will not reach until the left score hits 9.
        reached = 1'b0;
        tgt     = 1'b0;
        n       = 0;
        while (n < 3000 && !reached) begin
            if (dbg_state == 2'd0)
                tgt = dbg_dy;
            p2_up   = tgt;
            p2_down = !tgt;
            frame_tick();
            n++;
            if (game_over)
                reached = 1'b1;
        end
        p2_up   = 1'b0;
        p2_down = 1'b0;
        check("over.reached", 32'(reached), 32'd1);
        check("over.state", 32'(dbg_state), ST_OVER);
        check("over.score_l", 32'(score_l), 32'd9);
        check("over.score_r", 32'(score_r), 32'd0);
        check("over.bx", 32'(dbg_bx), 32'd316);
        check("over.by", 32'(dbg_by), 32'd236);

        // Frozen in OVER: paddle requests ignored, background red, ball hidden.
        p1_up = 1'b1;
        for (int i = 0; i < 5; i++)
            frame_tick();
        p1_up = 1'b0;
        check("over.p1_frozen", 32'(dbg_p1_y), 32'd416);
        check("over.game_over", 32'(game_over), 32'd1);
        check("over.score_l_held", 32'(score_l), 32'd9);
        check("over.state_held", 32'(dbg_state), ST_OVER);
        check_pix("over.bg", 10'd100, 10'd100, 3'b100);
        check_pix("over.ball_hidden", 10'd316, 10'd236, 3'b100);
        check_pix("over.p1", 10'd20, 10'd420, 3'b111);
        check_pix("over.line", 10'd319, 10'd0, 3'b001);
        check_pix("over.blank", 10'd700, 10'd10, 3'b000);

        // Mid-frame reset while the pixel would otherwise be red background.
        @(negedge clk);
        Reset   = 1'b1;
        h_count = 10'd100;
        v_count = 10'd100;
        @(negedge clk);
        check("mrst.rgb", 32'(rgb), 32'd0);
        check("mrst.game_over", 32'(game_over), 32'd0);
        check_state("mrst", ST_SERVE, 316, 236, 1, 1, 208, 208, 0, 0);
        Reset   = 1'b0;
        h_count = 10'd1;
        v_count = 10'd480;
        frame_tick();
        check("mrst.tick1_state", 32'(dbg_state), ST_SERVE);
        check("mrst.tick1_bx", 32'(dbg_bx), 32'd316);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
